// File: rtl/lc3b_evict_buffer.sv
// Write-back eviction buffer between the last cache level and physical memory.
// Dirty lines are absorbed in a single handshake, kept in a circular FIFO and
// written to memory in the background, oldest first. A repeated eviction of a
// line that is still waiting is merged into the existing entry. Fill lookups
// are answered from the buffer, so a fill never reads stale memory.
//
// Drain FSM
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no memory write in flight; launch the head entry if count>0
//   S_WRITE | head entry presented on pmem_*; wait for pmem_resp to pop it
module lc3b_evict_buffer #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4,
    parameter int OFF_W  = $clog2(LINE_W / 8)
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic                      wb_write,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic [LINE_W-1:0]         wb_wdata,
    output logic                      wb_resp,

    input  logic [ADDR_W-1:0]         rd_addr,
    output logic                      rd_hit,
    output logic [LINE_W-1:0]         rd_data,

    output logic                      pmem_write,
    output logic [ADDR_W-1:0]         pmem_address,
    output logic [LINE_W-1:0]         pmem_wdata,
    input  logic                      pmem_resp,

    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [OFF_W-1:0] OFF_ZERO = '0;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t             r_state;
    logic [TAG_W-1:0]   r_tag   [DEPTH];
    logic [LINE_W-1:0]  r_data  [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [IDX_W-1:0]   r_head;
    logic [IDX_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_wb_resp;
    logic               r_pmem_write;
    logic [ADDR_W-1:0]  r_pmem_address;
    logic [LINE_W-1:0]  r_pmem_wdata;

    logic [TAG_W-1:0]   w_wb_tag;
    logic [TAG_W-1:0]   w_rd_tag;
    logic               w_req;
    logic               w_coal;
    logic [IDX_W-1:0]   w_coal_idx;
    logic               w_not_full;
    logic               w_alloc;
    logic               w_accept;
    logic               w_pop;
    logic [LINE_W-1:0]  w_launch_data;
    logic               w_unused_off;

    assign w_wb_tag     = wb_addr[ADDR_W-1:OFF_W];
    assign w_rd_tag     = rd_addr[ADDR_W-1:OFF_W];
    // Offset bits never take part in line compares.
    assign w_unused_off = ^{wb_addr[OFF_W-1:0], rd_addr[OFF_W-1:0]};

    // A request arriving while its own acknowledge is showing is the same
    // request still held by the requester, so it is not looked at again.
    assign w_req      = wb_write & ~r_wb_resp;
    assign w_not_full = (r_count != FULL_CNT);
    assign w_alloc    = w_req & ~w_coal & w_not_full;
    assign w_accept   = w_req & (w_coal | w_not_full);
    assign w_pop      = (r_state == S_WRITE) & pmem_resp;

    // Find a waiting entry of the same line; the entry being written to memory is off limits.
    always_comb begin
        w_coal     = 1'b0;
        w_coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_tag[i] == w_wb_tag) &&
                !((r_state == S_WRITE) && (IDX_W'(i) == r_head))) begin
                w_coal     = 1'b1;
                w_coal_idx = IDX_W'(i);
            end
        end
    end

    // Fill forwarding: walk from oldest to newest so the newest match wins.
    always_comb begin : fwd_search
        logic [IDX_W-1:0] v_idx;
        v_idx   = '0;
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_head + IDX_W'(k);
            if (r_valid[v_idx] && (r_tag[v_idx] == w_rd_tag)) begin
                rd_hit  = 1'b1;
                rd_data = r_data[v_idx];
            end
        end
    end

    // Line storage: merge into an existing entry or write the new one at tail.
    always_ff @(posedge clk) begin
        if (w_req && w_coal) begin
            r_data[w_coal_idx] <= wb_wdata;
        end else if (w_alloc) begin
            r_tag[r_tail]  <= w_wb_tag;
            r_data[r_tail] <= wb_wdata;
        end
    end

    // FIFO bookkeeping: valid bits, pointers, occupancy and the acknowledge pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_wb_resp <= 1'b0;
        end else begin
            r_wb_resp <= w_accept;
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + IDX_W'(1);
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + IDX_W'(1);
            end
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // When the head is merged on the launch edge, the fresh data must go out,
    // otherwise the merged line would be popped without ever reaching memory.
    assign w_launch_data = (w_req && w_coal && (w_coal_idx == r_head)) ? wb_wdata
                                                                      : r_data[r_head];

    // Drain FSM with registered memory-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state        <= S_WRITE;
                        r_pmem_write   <= 1'b1;
                        r_pmem_address <= {r_tag[r_head], OFF_ZERO};
                        r_pmem_wdata   <= w_launch_data;
                    end
                end
                S_WRITE: begin
                    if (pmem_resp) begin
                        r_state      <= S_IDLE;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end

    assign wb_resp      = r_wb_resp;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;
    assign count        = r_count;
    assign empty        = (r_count == '0);

endmodule

// File: tb/tb_lc3b_evict_buffer.sv
// Bench for lc3b_evict_buffer: directed scenarios plus a random phase, all
// checked against a queue-level model of the buffer. Memory writes predicted
// by the model go into a scoreboard that a separate monitor drains.
module tb_lc3b_evict_buffer;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;
    localparam int LBYTES = LINE_W / 8;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } ent_t;

    logic              clk;
    logic              reset_n;
    logic              wb_write;
    logic [ADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0] wb_wdata;
    logic              wb_resp;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_hit;
    logic [LINE_W-1:0] rd_data;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic              empty;
    logic [2:0]        count;

    lc3b_evict_buffer #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wb_write     (wb_write),
        .wb_addr      (wb_addr),
        .wb_wdata     (wb_wdata),
        .wb_resp      (wb_resp),
        .rd_addr      (rd_addr),
        .rd_hit       (rd_hit),
        .rd_data      (rd_data),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .empty        (empty),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(LBYTES - 1);
    endfunction

    // ---------------- reference model ----------------
    ent_t mq[$];          // buffered lines, oldest first
    bit   m_inflight;     // oldest line is out on the memory bus
    bit   m_resp;         // acknowledge expected in the current cycle
    ent_t exp_wr[$];      // scoreboard of memory writes still to be seen

    initial begin
        m_inflight = 0;
        m_resp     = 0;
    end

    always @(posedge clk) begin
        int cj;
        bit req, acc, launch, pop;
        ent_t e;
        if (reset_n) begin
            cj  = -1;
            req = wb_write && !m_resp;
            if (req)
                for (int j = 0; j < mq.size(); j++)
                    if (!(m_inflight && j == 0) && mq[j].addr == line_of(wb_addr))
                        cj = j;
            acc    = req && (cj >= 0 || mq.size() < DEPTH);
            pop    = m_inflight && pmem_resp;
            launch = !m_inflight && mq.size() > 0;
            if (req && cj >= 0) mq[cj].data = wb_wdata;
            if (launch) begin
                exp_wr.push_back(mq[0]);
                m_inflight = 1;
            end
            if (pop) begin
                void'(mq.pop_front());
                m_inflight = 0;
            end
            if (req && cj < 0 && acc) begin
                e.addr = line_of(wb_addr);
                e.data = wb_wdata;
                mq.push_back(e);
            end
            m_resp = acc;
        end
    end

    // ---------------- monitor ----------------
    bit prev_pw = 0;

    always @(posedge clk) begin
        bit hit;
        logic [LINE_W-1:0] d;
        ent_t e;
        #2;
        if (reset_n) begin
            check("wb_resp", wb_resp, m_resp);
            check("count", count, mq.size());
            check("empty", empty, mq.size() == 0);
            hit = 0;
            d   = '0;
            for (int j = 0; j < mq.size(); j++)
                if (mq[j].addr == line_of(rd_addr)) begin
                    hit = 1;
                    d   = mq[j].data;
                end
            check("rd_hit", rd_hit, hit);
            check("rd_data", rd_data, d);
            if (pmem_write && !prev_pw) begin
                if (exp_wr.size() == 0) begin
                    fail_now("unexpected_pmem_write");
                end else begin
                    e = exp_wr.pop_front();
                    check("pmem_address", pmem_address, e.addr);
                    check("pmem_wdata", pmem_wdata, e.data);
                end
            end
            prev_pw = pmem_write;
        end else begin
            prev_pw = 0;
        end
    end

    // ---------------- memory responder ----------------
    int resp_mode = 0;   // 0: never respond, 1: random, 2: always respond

    initial begin
        pmem_resp = 1'b0;
        forever begin
            @(negedge clk);
            case (resp_mode)
                0:       pmem_resp = 1'b0;
                1:       pmem_resp = ($urandom_range(0, 2) == 0);
                default: pmem_resp = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic evict(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        int w;
        @(negedge clk);
        wb_write = 1'b1;
        wb_addr  = a;
        wb_wdata = d;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!wb_resp && w < 200);
        if (!wb_resp) fail_now("evict_ack_timeout");
        wb_write = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain_all();
        int w;
        resp_mode = 2;
        w = 0;
        while ((mq.size() != 0 || m_inflight) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (mq.size() != 0 || m_inflight) fail_now("drain_timeout");
        cycles(1);
        check("drained_empty", empty, 1'b1);
        check("drained_scoreboard", exp_wr.size(), 0);
        resp_mode = 0;
        cycles(1);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        return ADDR_W'(32'h6000 | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15));
    endfunction

    function automatic logic [LINE_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [LINE_W-1:0] d_old, d_new;
        bit active;
        int wait_c;

        reset_n  = 1'b0;
        wb_write = 1'b0;
        wb_addr  = '0;
        wb_wdata = '0;
        rd_addr  = '0;
        cycles(2);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_wb_resp", wb_resp, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_count", count, 0);
        check("rst_pmem_address", pmem_address, 0);
        check("rst_pmem_wdata", pmem_wdata, 0);
        reset_n = 1'b1;

        // single eviction
        resp_mode = 0;
        evict(16'h1230, {16{8'hA5}});
        cycles(3);
        check("single_pmem_write", pmem_write, 1'b1);
        check("single_pmem_address", pmem_address, 16'h1230);
        drain_all();

        // fill and stall
        for (int i = 0; i < 4; i++)
            evict(ADDR_W'(16'h7000 + i * 16), LINE_W'(128'h100 + i));
        check("fill_count", count, 4);
        fork
            evict(16'h7040, LINE_W'(128'h105));
        join_none
        cycles(6);
        check("stall_no_ack", wb_resp, 1'b0);
        check("stall_count", count, 4);
        resp_mode = 2;
        wait fork;
        drain_all();

        // coalescing into a waiting (non-head) entry
        evict(16'h1000, LINE_W'(128'hCAFE));
        evict(16'h2000, {4{32'hD1D1D1D1}});
        evict(16'h2008, {4{32'hD2D2D2D2}});
        check("coal_count", count, 2);
        drain_all();

        // eviction matching the line being written
        d_old = {4{32'h0DD0DD00}};
        d_new = {4{32'h0E0E0E0E}};
        evict(16'h3000, d_old);
        cycles(2);
        check("drainmatch_in_write", pmem_write, 1'b1);
        evict(16'h3000, d_new);
        check("drainmatch_count", count, 2);
        drain_all();

        // forwarding
        evict(16'h4000, {4{32'hD3D3D3D3}});
        rd_addr = 16'h4004;
        #1;
        check("fwd_hit", rd_hit, 1'b1);
        check("fwd_data", rd_data, {4{32'hD3D3D3D3}});
        rd_addr = 16'h5000;
        #1;
        check("fwd_miss", rd_hit, 1'b0);
        check("fwd_miss_data", rd_data, 0);
        drain_all();

        // asynchronous reset in the middle of a memory write
        evict(16'h8000, LINE_W'(128'h80));
        evict(16'h8010, LINE_W'(128'h81));
        evict(16'h8020, LINE_W'(128'h82));
        cycles(1);
        check("arst_pre_write", pmem_write, 1'b1);
        check("arst_pre_count", count, 3);
        #3;
        reset_n = 1'b0;
        mq.delete();
        exp_wr.delete();
        m_inflight = 0;
        m_resp     = 0;
        #1;
        check("arst_pmem_write", pmem_write, 1'b0);
        check("arst_count", count, 0);
        check("arst_empty", empty, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        evict(16'h9000, LINE_W'(128'h90));
        check("arst_slot0_valid", dut.r_valid[0], 1'b1);
        check("arst_tail_after", dut.r_tail, 1);
        drain_all();

        // random traffic
        resp_mode = 1;
        active = 0;
        wait_c = 0;
        repeat (3000) begin
            @(negedge clk);
            rd_addr = rand_addr();
            if (active) begin
                if (wb_resp) begin
                    active   = 0;
                    wait_c   = 0;
                    wb_write = 1'b0;
                    if ($urandom_range(0, 1) == 1) begin
                        wb_write = 1'b1;
                        wb_addr  = rand_addr();
                        wb_wdata = rand_data();
                        active   = 1;
                    end
                end else begin
                    wait_c++;
                    if (wait_c > 200) begin
                        fail_now("random_ack_timeout");
                        wb_write = 1'b0;
                        active   = 0;
                        wait_c   = 0;
                    end
                end
            end else if ($urandom_range(0, 3) == 0) begin
                wb_write = 1'b1;
                wb_addr  = rand_addr();
                wb_wdata = rand_data();
                active   = 1;
            end
        end
        if (active) begin
            wait_c = 0;
            while (!wb_resp && wait_c < 200) begin
                @(negedge clk);
                wait_c++;
            end
            if (!wb_resp) fail_now("random_final_ack_timeout");
            wb_write = 1'b0;
        end
        drain_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3b_evict_buffer.md
# lc3b_evict_buffer

Parametrised write-back eviction buffer between the lowest cache level and physical memory. It absorbs dirty-line evictions in one handshake and drains them to memory in the background in FIFO order. It merges repeated evictions to the same line and forwards buffered data to line fills, so a fill never reads stale memory. It generalises the fixed 128-bit `lc3b_datbus` line path to any line width, address width and depth.

## Interface
- `LINE_W`, 128, line width in bits; a multiple of 8, power of two.
- `ADDR_W`, 16, byte-address width.
- `DEPTH`, 4, number of entries; a power of two, at least 2.
- `OFF_W`, `$clog2(LINE_W/8)`, derived; line-offset bits ignored in compares.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wb_write` in 1: eviction request; held high until `wb_resp`.
- `wb_addr` in ADDR_W: eviction line address.
- `wb_wdata` in LINE_W: eviction line data.
- `wb_resp` out 1: one-cycle acceptance pulse.
- `rd_addr` in ADDR_W: lookup address from the fill path.
- `rd_hit` out 1: a valid entry matches `rd_addr`; combinational.
- `rd_data` out LINE_W: data of the matching entry; combinational.
- `pmem_write` out 1: memory write request; registered.
- `pmem_address` out ADDR_W: head entry address, with offset bits forced to 0.
- `pmem_wdata` out LINE_W: head entry data.
- `pmem_resp` in 1: memory write complete.
- `empty` out 1: count equals 0; used by the controller as a fence.
- `count` out $clog2(DEPTH)+1: number of valid entries.

## Operation
- **Storage:** circular FIFO with `head`, `tail`, `count` and a per-entry valid bit. The tag is `addr[ADDR_W-1:OFF_W]`.
- **Accept:** on an edge where `wb_write`=1 and `wb_resp`=0, the block accepts the request if it either coalesces or finds a free entry. An accepted request raises `wb_resp` for exactly the next cycle.
- **Ignore rule:** `wb_write` is ignored during the cycle `wb_resp`=1, so no request is captured twice.
- **Coalesce:** the request coalesces when its tag matches a valid entry that is not the entry currently being drained. That entry's data is overwritten; `count` and `tail` are unchanged. A coalescing request is accepted even when the buffer is full.
- **Allocate:** otherwise, if `count`<DEPTH, the request is written at `tail`, `tail` increments modulo DEPTH, and `count` increments.
- **Full:** if `count`=DEPTH and the request does not coalesce, it is not accepted. `wb_resp` stays 0 and the requester holds the request.
- **Drain FSM, IDLE:** if `count`>0, go to WRITE and register `pmem_write`=1 with the head address and data.
- **Drain FSM, WRITE:** hold `pmem_write` and the head address/data stable until `pmem_resp`=1. On that edge, invalidate the head, increment `head` modulo DEPTH, decrement `count`, drop `pmem_write` and return to IDLE.
- **Simultaneous events:** a pop and an allocation on the same edge leave `count` unchanged. Fullness is evaluated on pre-edge `count`, so a full buffer accepts a non-coalescing request no earlier than the edge after the pop.
- **Drain-entry match:** a request matching only the draining entry allocates a new entry; the in-flight write is never modified.
- **Forwarding:** `rd_hit`/`rd_data` reflect the newest matching entry, so a non-head match beats the draining head. With no match, `rd_hit`=0 and `rd_data`=0.

## Timing
- **Reset values:** assertion of `reset_n` clears, asynchronously, all valid bits, `head`, `tail`, `count` and the FSM (to IDLE). It also drives `pmem_write`=0, `wb_resp`=0, `empty`=1, `count`=0 and `pmem_address`/`pmem_wdata`=0.
- **Reset mid-operation:** an in-flight memory write is abandoned and its entry is lost.
- **Accept latency:** a request is accepted in 1 cycle when not full; `wb_resp` is high in the cycle after capture.
- **Drain latency:** the first `pmem_write` rises 1 cycle after the entry is valid, i.e. the edge after allocation. There is one IDLE cycle between consecutive drains.
- **Forwarding timing:** `rd_hit` reflects state after the most recent edge; a line accepted on edge N is visible to lookups from edge N on.
- **Wrap-around:** `head`/`tail` wrap from DEPTH-1 to 0. `count` distinguishes full from empty.

## Test plan
- **Single eviction:** after reset, evict addr 0x1230, data 0xA5 repeated. Required: `wb_resp` for 1 cycle, then `pmem_write` with `pmem_address`=0x1230; with `pmem_resp` after 3 cycles, `empty`=1 afterwards.
- **Fill and stall:** with `pmem_resp` held 0, evict 5 distinct lines with DEPTH=4. Required: 4 acks, then `wb_resp` stays 0 and `count`=4. Releasing `pmem_resp` gives the 5th ack on the edge after the first pop, with writes in order.
- **Coalescing:** evict 0x2000 (data D1), then 0x2008 (same line, D2) while the 0x2000 entry is not the head. Required: `count` does not increase, and memory receives 0x2000 with D2 exactly once.
- **Draining-entry match:** while the head 0x3000 is in WRITE, evict 0x3000 with new data. Required: a new entry is allocated, the first write completes with the old data, and a second write carries the new data.
- **Forwarding:** with 0x4000 (D3) buffered, set `rd_addr`=0x4004. Required: `rd_hit`=1 and `rd_data`=D3; `rd_addr`=0x5000 gives `rd_hit`=0.
- **Async reset:** assert `reset_n`=0 mid-WRITE with 3 entries. Required: `pmem_write` falls before the next edge, `count`=0 and `empty`=1; the next eviction lands at index 0.
